// File: rtl/attention_av_matmul.sv
// attention_av_matmul: Out[l][n][e] = sum_k A[l][n][k] * V[k][n][e]
// Captures A and V in one cycle and runs one signed MAC per cycle, with k
// innermost. Each finished sum is shifted right by FRAC_BITS and narrowed.
// The packed result is presented with a one-cycle done/out_valid pulse.
// Optional build macro:
//   ATTN_AV_SAT_EN - clamp the shifted result to the signed DATA_WIDTH range
//                    instead of keeping only its low bits.
module attention_av_matmul #(
    parameter int DATA_WIDTH = 16,
    parameter int L          = 8,
    parameter int N          = 1,
    parameter int E          = 8,
    parameter int FRAC_BITS  = 15
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [DATA_WIDTH*L*N*L-1:0]    A_in,
    input  logic [DATA_WIDTH*L*N*E-1:0]    V_in,
    output logic [DATA_WIDTH*L*N*E-1:0]    Out,
    output logic                           done,
    output logic                           out_valid
);

    localparam int DW = DATA_WIDTH;
    localparam int PW = 2 * DW;
    localparam int AW = 2 * DW + $clog2(L) + 1;
    localparam int LW = $clog2(L > 1 ? L : 2);
    localparam int NW = $clog2(N > 1 ? N : 2);
    localparam int EW = $clog2(E > 1 ? E : 2);

    localparam logic [LW-1:0] L_MAX = LW'(L - 1);
    localparam logic [NW-1:0] N_MAX = NW'(N - 1);
    localparam logic [EW-1:0] E_MAX = EW'(E - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_MAC  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]           state;
    logic [LW-1:0]        l_cnt;
    logic [NW-1:0]        n_cnt;
    logic [EW-1:0]        e_cnt;
    logic [LW-1:0]        k_cnt;
    logic signed [AW-1:0] acc;

    logic signed [DW-1:0] a_arr   [L][N][L];
    logic signed [DW-1:0] v_arr   [L][N][E];
    logic signed [DW-1:0] out_arr [L][N][E];

    logic signed [PW-1:0] a_ext, v_ext, prod;
    logic signed [AW-1:0] acc_base, sum;
    logic [DW-1:0]        res;
    logic                 k_last, e_last, n_last, l_last;

    assign k_last = (k_cnt == L_MAX);
    assign e_last = (e_cnt == E_MAX);
    assign n_last = (n_cnt == N_MAX);
    assign l_last = (l_cnt == L_MAX);

`ifdef ATTN_AV_SAT_EN
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    logic signed [AW-1:0] shifted;
`endif

    // Current product, running sum (restarted at k==0) and narrowed result
    always_comb begin
        a_ext    = PW'(a_arr[l_cnt][n_cnt][k_cnt]);
        v_ext    = PW'(v_arr[k_cnt][n_cnt][e_cnt]);
        prod     = a_ext * v_ext;
        acc_base = (k_cnt == '0) ? '0 : acc;
        sum      = acc_base + AW'(prod);
`ifdef ATTN_AV_SAT_EN
        shifted  = sum >>> FRAC_BITS;
        if (shifted > SAT_MAX)
            res = SAT_MAX[DW-1:0];
        else if (shifted < SAT_MIN)
            res = SAT_MIN[DW-1:0];
        else
            res = shifted[DW-1:0];
`else
        // Arithmetic shift followed by truncation: only these bits survive
        res = sum[FRAC_BITS +: DW];
`endif
    end

    // Operand capture during the single load cycle
    always_ff @(posedge clk) begin
        if (state == S_LOAD) begin
            for (int l = 0; l < L; l++)
                for (int n = 0; n < N; n++) begin
                    for (int k = 0; k < L; k++)
                        a_arr[l][n][k] <= A_in[((l*N*L) + (n*L) + k)*DW +: DW];
                    for (int e = 0; e < E; e++)
                        v_arr[l][n][e] <= V_in[((l*N*E) + (n*E) + e)*DW +: DW];
                end
        end
    end

    // Store each finished element when its reduction completes
    always_ff @(posedge clk) begin
        if (state == S_MAC && k_last)
            out_arr[l_cnt][n_cnt][e_cnt] <= res;
    end

    // Control FSM, loop counters, accumulator and result/handshake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            l_cnt     <= '0;
            n_cnt     <= '0;
            e_cnt     <= '0;
            k_cnt     <= '0;
            acc       <= '0;
            Out       <= '0;
            done      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            done      <= 1'b0;
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start)
                        state <= S_LOAD;
                end
                S_LOAD: begin
                    l_cnt <= '0;
                    n_cnt <= '0;
                    e_cnt <= '0;
                    k_cnt <= '0;
                    state <= S_MAC;
                end
                S_MAC: begin
                    acc <= sum;
                    if (!k_last) begin
                        k_cnt <= k_cnt + 1'b1;
                    end else begin
                        k_cnt <= '0;
                        if (!e_last) begin
                            e_cnt <= e_cnt + 1'b1;
                        end else begin
                            e_cnt <= '0;
                            if (!n_last) begin
                                n_cnt <= n_cnt + 1'b1;
                            end else begin
                                n_cnt <= '0;
                                if (!l_last) begin
                                    l_cnt <= l_cnt + 1'b1;
                                end else begin
                                    l_cnt <= '0;
                                    state <= S_DONE;
                                end
                            end
                        end
                    end
                end
                S_DONE: begin
                    for (int l = 0; l < L; l++)
                        for (int n = 0; n < N; n++)
                            for (int e = 0; e < E; e++)
                                Out[((l*N*E) + (n*E) + e)*DW +: DW] <= out_arr[l][n][e];
                    done      <= 1'b1;
                    out_valid <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
